// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_pkg: shared types and constants for the memory copy/fill engine.
//   state_t        - engine FSM state encoding
//   MODE_COPY/FILL - values of the Mode input
//   MEM_WORDS      - depth of the attached 1K x 32 data memory
//   WORD_BYTES     - pointer step per transferred word
package mem_copy_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 11;
  localparam int MEM_WORDS  = 1024;
  localparam int WORD_BYTES = 4;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_if: DataMemory port set owned by the copy engine while it is busy.
//   master - the engine (drives address, write data, strobes; reads ReadData)
//   slave  - the data memory (combinational ReadData)
interface mem_copy_if;
  import mem_copy_pkg::*;

  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] MemReadData;

  modport master (
    output MemAddress,
    output MemWriteData,
    output MemWrite,
    output MemRead,
    input  MemReadData
  );

  modport slave (
    input  MemAddress,
    input  MemWriteData,
    input  MemWrite,
    input  MemRead,
    output MemReadData
  );

endinterface

// File: rtl/mem_copy_engine_range_check.sv
// mem_copy_range_check: flags a byte address that is misaligned, lies outside
// the 4 KB data memory window, or whose block of count_i words runs past the
// last memory word.
//   addr_i     - block start byte address
//   count_i    - block length in words
//   check_en_i - qualifies the check (address unused -> never bad)
//   bad_o      - block is illegal
module mem_copy_range_check
  import mem_copy_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              check_en_i,
  output logic              bad_o
);

  // 10-bit word index + 11-bit count fits in 12 bits without wrap.
  logic [11:0] end_word;

  assign end_word = {2'b00, addr_i[11:2]} + {1'b0, count_i};

  assign bad_o = check_en_i &&
                 ((addr_i[1:0] != 2'b00) ||
                  (addr_i[ADDR_W-1:12] != '0) ||
                  (end_word > 12'(MEM_WORDS)));

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-block copy / fill initiator on the DataMemory port.
//   Clk, Reset               - clock, synchronous active-high reset
//   Start, Mode              - request pulse (IDLE only), 0=copy 1=fill
//   SrcAddr, DstAddr         - block byte addresses (src used in copy only)
//   WordCount, FillValue     - block length, fill word
//   Abort                    - terminate the active transfer
//   Busy, Done, Error        - status; Done/Error are 1-cycle pulses
//   WordsDone                - completed writes, held until next Start
//   mem                      - DataMemory port (master side)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for Start, bus released
// S_RD   | reading source word into buffer (copy only)
// S_WR   | writing buffer (copy) or fill word to destination
// S_DONE | one-cycle Done pulse, Error if rejected or aborted
module mem_copy_engine
  import mem_copy_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [CNT_W-1:0]  WordCount,
  input  logic [DATA_W-1:0] FillValue,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [CNT_W-1:0]  WordsDone,
  mem_copy_if.master        mem
);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              err_q, err_d;

  logic              src_bad, dst_bad;
  logic [CNT_W-1:0]  words_inc;

  mem_copy_range_check u_src_check (
    .addr_i     (SrcAddr),
    .count_i    (WordCount),
    .check_en_i (Mode == MODE_COPY),
    .bad_o      (src_bad)
  );

  mem_copy_range_check u_dst_check (
    .addr_i     (DstAddr),
    .count_i    (WordCount),
    .check_en_i (1'b1),
    .bad_o      (dst_bad)
  );

  assign words_inc = words_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    words_d = words_q;
    err_d   = err_q;

    mem.MemAddress   = '0;
    mem.MemWriteData = '0;
    mem.MemWrite     = 1'b0;
    mem.MemRead      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          cnt_d   = WordCount;
          fill_d  = FillValue;
          words_d = '0;
          err_d   = 1'b0;
          if (src_bad || dst_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (WordCount == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = (Mode == MODE_FILL) ? S_WR : S_RD;
          end
        end
      end

      S_RD: begin
        mem.MemAddress = src_q;
        mem.MemRead    = !Abort;
        buf_d          = mem.MemReadData;
        if (Abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WR;
        end
      end

      S_WR: begin
        mem.MemAddress   = dst_q;
        mem.MemWrite     = !Abort;
        mem.MemWriteData = (mode_q == MODE_FILL) ? fill_q : buf_q;
        if (Abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dst_d   = dst_q + ADDR_W'(WORD_BYTES);
          src_d   = src_q + ADDR_W'(WORD_BYTES);
          words_d = words_inc;
          if (words_inc == cnt_q) begin
            state_d = S_DONE;
          end else begin
            state_d = (mode_q == MODE_FILL) ? S_WR : S_RD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Error     = (state_q == S_DONE) && err_q;
  assign WordsDone = words_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed and randomized transfers against a
// word-array reference model of the copy/fill engine.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Mode, Abort;
  logic [31:0] SrcAddr, DstAddr, FillValue;
  logic [10:0] WordCount;
  logic        Busy, Done, Error;
  logic [10:0] WordsDone;

  logic [31:0] dut_mem [1024];
  logic [31:0] ref_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_copy_if bus ();

  mem_copy_engine dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Mode      (Mode),
    .SrcAddr   (SrcAddr),
    .DstAddr   (DstAddr),
    .WordCount (WordCount),
    .FillValue (FillValue),
    .Abort     (Abort),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .WordsDone (WordsDone),
    .mem       (bus)
  );

  assign bus.MemReadData = dut_mem[bus.MemAddress[11:2]];

  always @(posedge Clk) begin
    if (bus.MemWrite) dut_mem[bus.MemAddress[11:2]] <= bus.MemWriteData;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (dut_mem[i] !== ref_mem[i]) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  Busy, 0);
    check_eq({tag, "_done"},  Done, 0);
    check_eq({tag, "_err"},   Error, 0);
    check_eq({tag, "_words"}, WordsDone, 0);
    check_eq({tag, "_rd"},    bus.MemRead, 0);
    check_eq({tag, "_wr"},    bus.MemWrite, 0);
    check_eq({tag, "_addr"},  bus.MemAddress, 0);
    check_eq({tag, "_wdata"}, bus.MemWriteData, 0);
  endtask

  // abort_cyc: cycle (Start edge = 0) in which Abort is held high, 0 = none.
  // poke: pulse Start again in cycle 2 while the engine is busy.
  task automatic run_op(input string tag, input logic m, input logic [31:0] s,
                        input logic [31:0] d, input int cnt, input logic [31:0] fv,
                        input int abort_cyc, input bit poke);
    longint ls, ld;
    bit     bad, exp_err, got_err;
    int     full, exp_done, exp_words, exp_rd, exp_wr;
    int     got_done, got_rd, got_wr, busy_low, got_words;

    ls = longint'(s);
    ld = longint'(d);
    bad = (ld % 4 != 0) || (ld >= 4096) || (ld / 4 + cnt > 1024);
    if (m == MODE_COPY)
      bad = bad || (ls % 4 != 0) || (ls >= 4096) || (ls / 4 + cnt > 1024);
    full = (m == MODE_COPY) ? 2 * cnt : cnt;

    if (bad) begin
      exp_done = 1; exp_err = 1; exp_words = 0; exp_rd = 0; exp_wr = 0;
    end else if (cnt == 0) begin
      exp_done = 1; exp_err = 0; exp_words = 0; exp_rd = 0; exp_wr = 0;
    end else if (abort_cyc >= 1 && abort_cyc <= full) begin
      exp_done = abort_cyc + 1;
      exp_err  = 1;
      if (m == MODE_COPY) begin
        exp_words = (abort_cyc - 1) / 2;
        exp_rd    = abort_cyc / 2;
      end else begin
        exp_words = abort_cyc - 1;
        exp_rd    = 0;
      end
      exp_wr = exp_words;
    end else begin
      exp_done = full + 1; exp_err = 0; exp_words = cnt;
      exp_rd = (m == MODE_COPY) ? cnt : 0;
      exp_wr = cnt;
    end

    // Forward word order so that overlapping blocks propagate like the hardware.
    for (int i = 0; i < exp_words; i++) begin
      if (m == MODE_COPY) ref_mem[int'(ld / 4) + i] = ref_mem[int'(ls / 4) + i];
      else                ref_mem[int'(ld / 4) + i] = fv;
    end

    @(negedge Clk);
    Mode = m; SrcAddr = s; DstAddr = d; WordCount = cnt[10:0]; FillValue = fv;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    got_done = 0; got_rd = 0; got_wr = 0; busy_low = 0; got_err = 0; got_words = 0;
    for (int c = 1; c <= 2 * 1024 + 8; c++) begin
      Start = poke && (c == 2);
      Abort = (c == abort_cyc);
      #1;
      if (bus.MemRead)  got_rd++;
      if (bus.MemWrite) got_wr++;
      if (!Busy)        busy_low++;
      if (Done) begin
        got_done  = c;
        got_err   = Error;
        got_words = WordsDone;
        break;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    Abort = 1'b0;

    check_eq({tag, "_done_cycle"}, got_done, exp_done);
    check_eq({tag, "_error"}, got_err, exp_err);
    check_eq({tag, "_words"}, got_words, exp_words);
    check_eq({tag, "_reads"}, got_rd, exp_rd);
    check_eq({tag, "_writes"}, got_wr, exp_wr);
    check_eq({tag, "_busy_gap"}, busy_low, 0);
    @(negedge Clk);
    check_eq({tag, "_idle_busy"}, Busy, 0);
    check_eq({tag, "_held_words"}, WordsDone, exp_words);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    int    idx_s, idx_d, cnt, ab;
    logic  m;
    logic [31:0] s, d, fv;

    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Abort = 1'b0;
    SrcAddr = '0; DstAddr = '0; WordCount = '0; FillValue = '0;
    for (int i = 0; i < 1024; i++) begin
      dut_mem[i] = $urandom;
      ref_mem[i] = dut_mem[i];
    end
    repeat (3) @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b0;

    dut_mem[0] = 32'h30e; dut_mem[1] = 32'h50; dut_mem[2] = 32'h369; dut_mem[3] = 32'h23e;
    for (int i = 0; i < 4; i++) ref_mem[i] = dut_mem[i];
    run_op("copy4", MODE_COPY, 32'h0, 32'h100, 4, 32'h0, 0, 0);

    run_op("fill3", MODE_FILL, 32'h0, 32'h200, 3, 32'hDEADBEEF, 0, 0);

    run_op("err_src", MODE_COPY, 32'h2, 32'h400, 4, 32'h0, 0, 0);
    run_op("err_range", MODE_COPY, 32'h0, 32'hFFC, 2, 32'h0, 0, 0);
    run_op("err_fill", MODE_FILL, 32'h0, 32'hFFC, 2, 32'h1234, 0, 0);
    run_op("err_hi", MODE_FILL, 32'h0, 32'h1000, 1, 32'h1234, 0, 0);
    run_op("cnt0", MODE_COPY, 32'h0, 32'h80, 0, 32'h0, 0, 0);
    run_op("fill_end", MODE_FILL, 32'h0, 32'hFF8, 2, 32'h55AA55AA, 0, 0);

    run_op("abort", MODE_COPY, 32'h10, 32'h500, 4, 32'h0, 4, 0);
    run_op("abort_done", MODE_FILL, 32'h0, 32'h540, 2, 32'h77, 3, 0);

    // Reset after two completed words of a four-word copy.
    @(negedge Clk);
    Mode = MODE_COPY; SrcAddr = 32'h20; DstAddr = 32'h600; WordCount = 11'd4; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    #1;
    check_idle_outputs("midreset");
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) ref_mem[384 + i] = ref_mem[8 + i];
    check_mem("midreset_mem");
    run_op("after_reset", MODE_FILL, 32'h0, 32'h600, 2, 32'hCAFEF00D, 0, 0);

    dut_mem[0] = 32'hA; ref_mem[0] = 32'hA;
    run_op("overlap", MODE_COPY, 32'h0, 32'h4, 3, 32'h0, 0, 1);

    for (int t = 0; t < 30; t++) begin
      m   = $urandom_range(0, 1);
      cnt = $urandom_range(0, 9);
      idx_s = ($urandom_range(0, 5) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1015);
      idx_d = ($urandom_range(0, 5) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1015);
      s = 32'(idx_s * 4);
      d = 32'(idx_d * 4);
      if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) d = d + 32'h1000;
      fv = $urandom;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * cnt + 2) : 0;
      run_op($sformatf("rnd%0d", t), m, s, d, cnt, fv, ab, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Bus-initiator block that drives the DataMemory port set (Address, WriteData, MemWrite, MemRead, ReadData) to perform word-block copy or fill operations without CPU involvement. It sits beside the single-cycle datapath and takes ownership of the data memory interface while Busy is high. It uses a start/done handshake with a 2-cycle-per-word copy and a 1-cycle-per-word fill. It checks alignment and range against the 1K x 32 memory.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, byte address width
MEM_WORDS, 1024, memory depth in words, indexed by Address[11:2]
CNT_W, 11, WordCount width, range 0..1024

Ports:
Clk  in  1  clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  request pulse, sampled only in IDLE
Mode  in  1  0 = copy, 1 = fill
SrcAddr  in  ADDR_W  source byte address, copy mode only
DstAddr  in  ADDR_W  destination byte address
WordCount  in  CNT_W  number of words to transfer
FillValue  in  DATA_W  word written in fill mode
Abort  in  1  terminate the active transfer
Busy  out  1  high in RD, WR and DONE
Done  out  1  1-cycle completion pulse
Error  out  1  1-cycle pulse, coincident with Done
WordsDone  out  CNT_W  count of completed writes, held until next Start
MemAddress  out  ADDR_W  to DataMemory Address
MemWriteData  out  DATA_W  to DataMemory WriteData
MemWrite  out  1  to DataMemory MemWrite
MemRead  out  1  to DataMemory MemRead
MemReadData  in  DATA_W  from DataMemory ReadData (combinational read)

Behaviour:
- Single clock, Clk. Reset is synchronous and active-high.
- Reset: state returns to IDLE and every output is 0, including WordsDone.
- States:
  - IDLE: wait for Start.
  - RD: MemRead=1, MemAddress=src pointer. MemReadData is captured into the buffer at the posedge.
  - WR: MemWrite=1, MemAddress=dst pointer, MemWriteData = buffer (copy) or FillValue (fill).
  - DONE: Done=1, then return to IDLE.
- In IDLE, DONE and RD, MemWriteData=0. In IDLE and DONE, MemAddress=0 and MemRead=MemWrite=0.
- On Start in IDLE:
  - Latch Mode, addresses, WordCount and FillValue. Clear WordsDone.
  - Error check: DstAddr[1:0]!=0; copy mode with SrcAddr[1:0]!=0; any used address with [31:12]!=0; or addr[11:2]+WordCount > MEM_WORDS. On error, go to DONE with Error=1 and perform no memory access.
  - WordCount=0: go to DONE with Error=0 and perform no memory access.
  - Otherwise go to RD (copy) or WR (fill).
- WR exit: dst pointer +4, src pointer +4, WordsDone+1. If WordsDone+1 == WordCount, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- Latency, with Start sampled at edge 0: copy of K words gives Done in cycle 2K+1; fill gives Done in cycle K+1. Busy is high from cycle 1 through the Done cycle.
- Start is ignored while not in IDLE.
- Copy is a strict forward word-by-word copy. Overlapping regions are not handled as memmove; a forward overlap propagates data.
- Abort, when high in RD or WR:
  - Combinationally suppresses that cycle's MemRead and MemWrite.
  - Next state is DONE with Error=1.
  - WordsDone keeps only the completed writes.
  - Abort has no effect in IDLE or DONE.
- Reset mid-transfer: IDLE at the next edge with no further accesses. Words already written remain in memory.

Decomposition:
- Package mem_copy_pkg holds:
  - the state enum (S_IDLE, S_RD, S_WR, S_DONE);
  - the MODE_COPY and MODE_FILL constants;
  - the MEM_WORDS and WORD_BYTES=4 constants.
- One combinational sub-module, mem_copy_range_check (address, count, check_en → bad). It is instantiated twice, once for src and once for dst.
- The FSM, pointers and buffer stay in the top module.

Test Plan:
1. Copy: preload mem[0..3]=0x30e,0x50,0x369,0x23e; Start with Mode=0, Src=0x0, Dst=0x100, Count=4 → mem[64..67] match the source; MemRead/MemWrite alternate over 8 cycles; Done in cycle 9; WordsDone=4; Error=0.
2. Fill: Dst=0x200, Count=3, FillValue=0xDEADBEEF → mem[128..130]=0xDEADBEEF; Done in cycle 4; MemRead never asserted.
3. Errors: Src=0x2, or Dst=0xFFC with Count=2 → Done=Error=1 in cycle 1; no MemRead/MemWrite; memory unchanged. Count=0 → Done in cycle 1 with Error=0.
4. Abort during the second WR of a Count=4 copy → MemWrite suppressed in that cycle; only mem[dst] written; WordsDone=1; Done=Error=1 next cycle.
5. Reset asserted after 2 words of a 4-word copy → Busy=0 and all outputs 0 at the next edge; only 2 destination words changed; a new Start is accepted.
6. Overlap: mem[0]=0xA, Src=0x0, Dst=0x4, Count=3 → mem[1..3]=0xA. Start pulsed while Busy → ignored.
